// File: rtl/control_fsm_pkg.sv
// Shared encodings for the instruction-sequencing FSM: states, opcode/op
// values, one-hot selects and the per-state control word.
package control_fsm_pkg;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WRITE_RD, S_WRITE_IMM
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RN   = 3'b100;

  localparam logic [3:0] VSEL_NONE  = 4'b0000;
  localparam logic [3:0] VSEL_C     = 4'b0001;
  localparam logic [3:0] VSEL_PC    = 4'b0010;
  localparam logic [3:0] VSEL_IMM8  = 4'b0100;
  localparam logic [3:0] VSEL_MDATA = 4'b1000;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore control word for a state; EXEC is only reached by MOV reg or ALU ops.
  function automatic ctrl_t ctrl_for(input state_e st, input logic [2:0] opcode,
                                     input logic [1:0] op);
    ctrl_t c;
    c      = '0;
    c.nsel = NSEL_NONE;
    c.vsel = VSEL_NONE;
    unique case (st)
      S_WAIT:  c.w = 1'b1;
      S_GET_A: begin c.nsel = NSEL_RN; c.loada = 1'b1; end
      S_GET_B: begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
      S_EXEC: begin
        c.aluop = (opcode == OPC_MOV) ? 2'b00 : op;
        c.asel  = (opcode == OPC_MOV) || (op == OP_MVN);
        if (opcode == OPC_ALU && op == OP_CMP) c.loads = 1'b1;
        else                                   c.loadc = 1'b1;
      end
      S_WRITE_RD:  begin c.nsel = NSEL_RD; c.vsel = VSEL_C;    c.write = 1'b1; end
      S_WRITE_IMM: begin c.nsel = NSEL_RN; c.vsel = VSEL_IMM8; c.write = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_fsm_instr_dec.sv
// Instruction field extraction, immediate sign extension and the
// nsel-driven register index Mux3.
module instr_dec
  import control_fsm_pkg::*;
(
  input  logic [15:0] ir_i,
  input  logic [2:0]  nsel_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [1:0]  shift_o,
  output logic [2:0]  readnum_o,
  output logic [15:0] sximm5_o,
  output logic [15:0] sximm8_o
);

  logic [2:0] rn, rd, rm;

  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn       = ir_i[10:8];
  assign rd       = ir_i[7:5];
  assign shift_o  = ir_i[4:3];
  assign rm       = ir_i[2:0];

  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};

  assign readnum_o = ({3{nsel_i[0]}} & rm)
                   | ({3{nsel_i[1]}} & rd)
                   | ({3{nsel_i[2]}} & rn);

endmodule

// File: rtl/control_fsm.sv
// Instruction register plus sequencing FSM; control outputs are registered
// from the next state so they line up with the state they belong to.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  nsel,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [3:0]  vsel,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [2:0]  opcode;
  logic [1:0]  op;

  instr_dec u_dec (
    .ir_i      (ir_q),
    .nsel_i    (ctrl_q.nsel),
    .opcode_o  (opcode),
    .op_o      (op),
    .shift_o   (shift),
    .readnum_o (readnum),
    .sximm5_o  (sximm5),
    .sximm8_o  (sximm8)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_WAIT: begin
        if (load) ir_d = in;
        if (s)    state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OPC_MOV && op == OP_MOV_IMM)
          state_d = S_WRITE_IMM;
        else if ((opcode == OPC_MOV && op == OP_MOV_REG) || (opcode == OPC_ALU && op == OP_MVN))
          state_d = S_GET_B;
        else if (opcode == OPC_ALU)
          state_d = S_GET_A;
        else
          state_d = S_WAIT;
      end
      S_GET_A: state_d = S_GET_B;
      S_GET_B: state_d = S_EXEC;
      S_EXEC:  state_d = (opcode == OPC_ALU && op == OP_CMP) ? S_WAIT : S_WRITE_RD;
      default: state_d = S_WAIT;
    endcase
    ctrl_d = ctrl_for(state_d, ir_d[15:13], ir_d[12:11]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      ctrl_q  <= ctrl_for(S_WAIT, 3'b000, 2'b00);
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign w        = ctrl_q.w;
  assign nsel     = ctrl_q.nsel;
  assign writenum = readnum;
  assign vsel     = ctrl_q.vsel;
  assign write    = ctrl_q.write;
  assign loada    = ctrl_q.loada;
  assign loadb    = ctrl_q.loadb;
  assign loadc    = ctrl_q.loadc;
  assign loads    = ctrl_q.loads;
  assign asel     = ctrl_q.asel;
  assign bsel     = ctrl_q.bsel;
  assign ALUop    = ctrl_q.aluop;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: stimulus queues cycle-stamped expected
// control vectors, a negedge monitor pops and compares them.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset_n, s, load;
  logic [15:0] in;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  nsel, readnum, writenum;
  logic [3:0]  vsel;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm5, sximm8;

  control_fsm dut (
    .clk(clk), .reset_n(reset_n), .s(s), .load(load), .in(in),
    .w(w), .nsel(nsel), .readnum(readnum), .writenum(writenum), .vsel(vsel),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .sximm5(sximm5), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  // strobe field order: {write, loada, loadb, loadc, loads, asel, bsel}
  localparam logic [6:0] ST_NONE = 7'b0000000;
  localparam logic [6:0] ST_WR   = 7'b1000000;
  localparam logic [6:0] ST_LA   = 7'b0100000;
  localparam logic [6:0] ST_LB   = 7'b0010000;
  localparam logic [6:0] ST_LC   = 7'b0001000;
  localparam logic [6:0] ST_LS   = 7'b0000100;
  localparam logic [6:0] ST_LCAS = 7'b0001010;

  typedef struct {
    int          cyc;
    string       name;
    logic [56:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [56:0] mk(input logic ew, input logic [2:0] ensel,
      input logic [2:0] ernum, input logic [3:0] evsel, input logic [6:0] est,
      input logic [1:0] esh, input logic [1:0] ealu, input logic [15:0] esx5,
      input logic [15:0] esx8);
    return {ew, ensel, ernum, ernum, evsel, est, esh, ealu, esx5, esx8};
  endfunction

  task automatic push(input int c, input string nm, input logic [56:0] v);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.v    = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [56:0] act;
    exp_t e;
    act = {w, nsel, readnum, writenum, vsel, write, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm5, sximm8};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc != cyc || act !== e.v) begin
        n_fail++;
        $display("FAIL %s @cyc %0d (due %0d): got %015h expected %015h",
                 e.name, cyc, e.cyc, act, e.v);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Loads word into IR, then raises s; c is the cycle in which s is first seen.
  task automatic start(input logic [15:0] word, output int c);
    load = 1'b1;
    in   = word;
    step(1);
    load = 1'b0;
    in   = 16'h1234;
    s    = 1'b1;
    c    = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset_n = 1'b0; s = 1'b0; load = 1'b0; in = '0;
    step(2);
    c = cyc;
    push(c, "reset_idle", mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
    reset_n = 1'b1;
    step(2);

    // MOV R0,#-3
    start(16'hD0FD, c);
    push(c,   "movi_wait",  mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b11, 2'b00, 16'hFFFD, 16'hFFFD));
    push(c+1, "movi_dec",   mk(0, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b11, 2'b00, 16'hFFFD, 16'hFFFD));
    push(c+2, "movi_wimm",  mk(0, 3'b100, 3'd0, 4'b0100, ST_WR,   2'b11, 2'b00, 16'hFFFD, 16'hFFFD));
    push(c+3, "movi_done",  mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b11, 2'b00, 16'hFFFD, 16'hFFFD));
    step(1); s = 1'b0;
    step(4);

    // ADD R2,R1,R0 LSL#1 with a load attempt during GET_B
    start(16'hA148, c);
    push(c,   "add_wait",  mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b01, 2'b00, 16'h0008, 16'h0048));
    push(c+1, "add_dec",   mk(0, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b01, 2'b00, 16'h0008, 16'h0048));
    push(c+2, "add_geta",  mk(0, 3'b100, 3'd1, 4'b0000, ST_LA,   2'b01, 2'b00, 16'h0008, 16'h0048));
    push(c+3, "add_getb",  mk(0, 3'b001, 3'd0, 4'b0000, ST_LB,   2'b01, 2'b00, 16'h0008, 16'h0048));
    push(c+4, "add_exec",  mk(0, 3'b000, 3'd0, 4'b0000, ST_LC,   2'b01, 2'b00, 16'h0008, 16'h0048));
    push(c+5, "add_wrd",   mk(0, 3'b010, 3'd2, 4'b0001, ST_WR,   2'b01, 2'b00, 16'h0008, 16'h0048));
    push(c+6, "add_done",  mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b01, 2'b00, 16'h0008, 16'h0048));
    step(1); s = 1'b0;
    step(2); load = 1'b1; in = 16'hFFFF;
    step(1); load = 1'b0;
    step(3);

    // CMP R1,R0
    start(16'hA900, c);
    push(c+1, "cmp_dec",   mk(0, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
    push(c+2, "cmp_geta",  mk(0, 3'b100, 3'd1, 4'b0000, ST_LA,   2'b00, 2'b00, 16'h0000, 16'h0000));
    push(c+3, "cmp_getb",  mk(0, 3'b001, 3'd0, 4'b0000, ST_LB,   2'b00, 2'b00, 16'h0000, 16'h0000));
    push(c+4, "cmp_exec",  mk(0, 3'b000, 3'd0, 4'b0000, ST_LS,   2'b00, 2'b01, 16'h0000, 16'h0000));
    push(c+5, "cmp_done",  mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
    step(1); s = 1'b0;
    step(5);

    // MOV R3,R3 LSL#1
    start(16'hC06B, c);
    push(c+1, "movr_dec",  mk(0, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b01, 2'b00, 16'h000B, 16'h006B));
    push(c+2, "movr_getb", mk(0, 3'b001, 3'd3, 4'b0000, ST_LB,   2'b01, 2'b00, 16'h000B, 16'h006B));
    push(c+3, "movr_exec", mk(0, 3'b000, 3'd0, 4'b0000, ST_LCAS, 2'b01, 2'b00, 16'h000B, 16'h006B));
    push(c+4, "movr_wrd",  mk(0, 3'b010, 3'd3, 4'b0001, ST_WR,   2'b01, 2'b00, 16'h000B, 16'h006B));
    push(c+5, "movr_done", mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b01, 2'b00, 16'h000B, 16'h006B));
    step(1); s = 1'b0;
    step(5);

    // MVN R4,R2 ASR
    start(16'hBA92, c);
    push(c+1, "mvn_dec",   mk(0, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b10, 2'b00, 16'hFFF2, 16'hFF92));
    push(c+2, "mvn_getb",  mk(0, 3'b001, 3'd2, 4'b0000, ST_LB,   2'b10, 2'b00, 16'hFFF2, 16'hFF92));
    push(c+3, "mvn_exec",  mk(0, 3'b000, 3'd0, 4'b0000, ST_LCAS, 2'b10, 2'b11, 16'hFFF2, 16'hFF92));
    push(c+4, "mvn_wrd",   mk(0, 3'b010, 3'd4, 4'b0001, ST_WR,   2'b10, 2'b00, 16'hFFF2, 16'hFF92));
    push(c+5, "mvn_done",  mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b10, 2'b00, 16'hFFF2, 16'hFF92));
    step(1); s = 1'b0;
    step(5);

    // illegal opcode 000
    start(16'h0000, c);
    push(c+1, "ill_dec",   mk(0, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
    push(c+2, "ill_done",  mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
    step(1); s = 1'b0;
    step(3);

    // reset during EXEC of an ADD aborts it and clears IR
    start(16'hA148, c);
    push(c+1, "rst_dec",   mk(0, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b01, 2'b00, 16'h0008, 16'h0048));
    push(c+2, "rst_geta",  mk(0, 3'b100, 3'd1, 4'b0000, ST_LA,   2'b01, 2'b00, 16'h0008, 16'h0048));
    push(c+3, "rst_getb",  mk(0, 3'b001, 3'd0, 4'b0000, ST_LB,   2'b01, 2'b00, 16'h0008, 16'h0048));
    push(c+4, "rst_exec",  mk(0, 3'b000, 3'd0, 4'b0000, ST_LC,   2'b01, 2'b00, 16'h0008, 16'h0048));
    push(c+5, "rst_abort", mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
    push(c+6, "rst_idle",  mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
    step(1); s = 1'b0;
    step(3); reset_n = 1'b0;
    step(1); reset_n = 1'b1;
    step(3);

    // s held high: back-to-back MOV imm restarts one cycle after WAIT
    start(16'hD0FD, c);
    push(c+1, "hold_dec1", mk(0, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b11, 2'b00, 16'hFFFD, 16'hFFFD));
    push(c+2, "hold_wim1", mk(0, 3'b100, 3'd0, 4'b0100, ST_WR,   2'b11, 2'b00, 16'hFFFD, 16'hFFFD));
    push(c+3, "hold_wait", mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b11, 2'b00, 16'hFFFD, 16'hFFFD));
    push(c+4, "hold_dec2", mk(0, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b11, 2'b00, 16'hFFFD, 16'hFFFD));
    push(c+5, "hold_wim2", mk(0, 3'b100, 3'd0, 4'b0100, ST_WR,   2'b11, 2'b00, 16'hFFFD, 16'hFFFD));
    push(c+6, "hold_done", mk(1, 3'b000, 3'd0, 4'b0000, ST_NONE, 2'b11, 2'b00, 16'hFFFD, 16'hFFFD));
    step(4); s = 1'b0;
    step(4);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have ports:
  clk  input  1  rising-edge clock
  reset_n  input  1  synchronous active-low reset
  s  input  1  start request, sampled only in WAIT
  load  input  1  instruction register load enable
  in  input  16  instruction word
  w  output  1  idle/ready flag
  nsel  output  3  one-hot register-field select: bit0 Rm, bit1 Rd, bit2 Rn
  readnum  output  3  register read index, Mux3 of Rm/Rd/Rn by nsel
  writenum  output  3  register write index, same value as readnum
  vsel  output  4  one-hot writeback select: bit0 C, bit1 PC, bit2 sximm8, bit3 mdata
  write  output  1  register file write strobe
  loada, loadb, loadc, loads  output  1 each  datapath register enables
  asel, bsel  output  1 each  force A to zero / select sximm5 for B
  shift  output  2  IR[4:3]
  ALUop  output  2  ALU operation
  sximm5  output  16  sign-extended IR[4:0]
  sximm8  output  16  sign-extended IR[7:0]
REQ-002 SHALL use one clock domain; reset_n SHALL be synchronous, active-low.

Function
REQ-003 SHALL hold a 16-bit IR that loads `in` on a clk edge only when load=1 and state=WAIT; load in any other state SHALL be ignored.
REQ-004 Instruction fields SHALL be: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], shift IR[4:3], Rm IR[2:0].
REQ-005 States SHALL be WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_RD, WRITE_IMM.
REQ-006 All outputs SHALL be Moore, decoded from the state and IR; any strobe not listed for a state SHALL be 0.
REQ-007 WAIT: w=1; s=1 -> DECODE; otherwise stay in WAIT.
REQ-008 DECODE transitions:
  110/10 (MOV imm) -> WRITE_IMM
  110/00 (MOV reg) or 101/11 (MVN) -> GET_B
  101/00, 101/01, 101/10 (ADD, CMP, AND) -> GET_A
  any other opcode/op -> WAIT, with no strobe asserted.
REQ-009 GET_A: nsel=100, loada=1 -> GET_B.
REQ-010 GET_B: nsel=001, loadb=1 -> EXEC.
REQ-011 EXEC:
  ALUop=op for ALU instructions; ALUop=00 for MOV reg
  asel=1 for MOV reg and MVN; bsel=0
  CMP: loads=1, loadc=0 -> WAIT
  all others: loadc=1 -> WRITE_RD.
REQ-012 WRITE_RD: nsel=010, vsel=0001, write=1 -> WAIT.
REQ-013 WRITE_IMM: nsel=100, vsel=0100, write=1 -> WAIT.
REQ-014 w SHALL be 0 in every state except WAIT.
REQ-015 Busy cycles (w=0) after the accepting edge SHALL be: MOV imm 2, MOV reg 4, MVN 4, CMP 4, ADD/AND 5, illegal 1.
REQ-016 If s is held high, a new instruction SHALL start on the edge after returning to WAIT, using the IR contents at that time.
REQ-017 sximm5, sximm8 and shift SHALL always reflect the current IR, in every state.

Reset
REQ-018 While reset_n=0 at a clk edge, the block SHALL enter WAIT and clear IR to 16'h0000, regardless of the current state.
REQ-019 The cycle after reset SHALL show w=1 and write, load*, asel, bsel = 0.
REQ-020 Reset asserted mid-instruction SHALL abort it; no write SHALL occur afterwards.

Structure
REQ-021 A shared constants file SHALL hold the state encodings, the opcode/op constants and the one-hot nsel/vsel constants.
REQ-022 One sub-module, instr_dec, SHALL perform field extraction, sign extension and the nsel-driven Mux3; control_fsm SHALL instantiate it.
REQ-023 IR and the state register SHALL be plain clocked registers with synchronous reset.

Verification
REQ-024 Reset: reset_n=0 for one edge from EXEC -> w=1, write=0, loadc=0, IR=16'h0000.
REQ-025 MOV R0,#-3, in=16'hD0FD, then s pulse:
  DECODE, then WRITE_IMM with write=1, writenum=0, vsel=0100, sximm8=16'hFFFD
  w=1 on the third cycle.
REQ-026 ADD R2,R1,R0 LSL#1, in=16'hA148, then s:
  GET_A: readnum=1, loada=1
  GET_B: readnum=0, loadb=1, shift=01
  EXEC: loadc=1, ALUop=00
  WRITE_RD: writenum=2, vsel=0001, write=1
  w=0 for 5 cycles.
REQ-027 CMP R1,R0, in=16'hA900 -> EXEC shows loads=1, loadc=0; write is never 1; return to WAIT after 4 cycles.
REQ-028 Busy load: load=1 with in=16'hFFFF during GET_B of an ADD -> IR unchanged; the ADD completes normally.
REQ-029 Illegal instruction, in=16'h0000, then s -> one DECODE cycle, then WAIT, with all strobes 0.
